// File: rtl/ones_word_enum_if.sv
// Handshake bundle for the fixed-weight word enumerator: request side plus output stream.
// master is the enumerator; slave is the requester/consumer.
interface ones_word_enum_if #(
  parameter int WIDTH = 12,
  parameter int CW    = 4,
  parameter int IW    = 10
);
  logic             start;
  logic [CW-1:0]    count;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_word;
  logic [IW-1:0]    out_index;
  logic             out_last;
  logic             busy;
  logic             done;
  logic             err;

  modport master (
    input  start, count, out_ready,
    output out_valid, out_word, out_index, out_last, busy, done, err
  );

  modport slave (
    output start, count, out_ready,
    input  out_valid, out_word, out_index, out_last, busy, done, err
  );
endinterface

// File: rtl/ones_word_enum.sv
// Enumerates every WIDTH-bit word of popcount k in increasing order, one per handshake.
// state | meaning
// IDLE  | waiting for start; rejects count > WIDTH with an err pulse
// EMIT  | presenting out_word; advances to the next same-weight word on handshake
// DONE  | one-cycle done pulse after the last word was accepted
module ones_word_enum #(
  parameter int WIDTH = 12,
  parameter int CW    = 4,
  parameter int IW    = 10
) (
  input logic               clk,
  input logic               rst,
  ones_word_enum_if.master  bus
);

  typedef enum logic [1:0] {IDLE, EMIT, DONE} state_t;

  state_t           state, state_nx;
  logic [CW-1:0]    k;
  logic [WIDTH-1:0] word;
  logic [IW-1:0]    index;
  logic             err_q;

  logic             accept;
  logic             reject;
  logic             last;
  logic             hs;
  logic [WIDTH-1:0] first_word;
  logic [WIDTH-1:0] last_word;
  logic [WIDTH-1:0] low_bit;
  logic [WIDTH-1:0] ripple;
  logic [WIDTH-1:0] spill;
  logic [WIDTH-1:0] next_word;
  logic [CW-1:0]    tz;

  assign accept = (state == IDLE) && bus.start && (bus.count <= CW'(WIDTH));
  assign reject = (state == IDLE) && bus.start && (bus.count > CW'(WIDTH));

  assign first_word = ~({WIDTH{1'b1}} << bus.count);
  assign last_word  = ~({WIDTH{1'b1}} >> k);
  assign last       = (state == EMIT) && (word == last_word);
  assign hs         = (state == EMIT) && bus.out_ready;

  // Same-popcount successor: carry the lowest run up one place, then
  // re-pack the displaced ones at the bottom (shift instead of divide).
  assign low_bit = word & (~word + WIDTH'(1));
  assign ripple  = word + low_bit;
  assign spill   = (ripple ^ word) >> 2;

  always_comb begin
    tz = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (low_bit[i]) tz = CW'(i);
    end
  end

  assign next_word = ripple | (spill >> tz);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept)      state_nx = EMIT;
      EMIT:    if (hs && last)  state_nx = DONE;
      DONE:                     state_nx = IDLE;
      default:                  state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      k     <= '0;
      word  <= '0;
      index <= '0;
      err_q <= 1'b0;
    end else begin
      err_q <= reject;
      if (accept) begin
        k     <= bus.count;
        word  <= first_word;
        index <= '0;
      end else if (hs && !last) begin
        word  <= next_word;
        index <= index + IW'(1);
      end
    end
  end

  assign bus.out_valid = (state == EMIT);
  assign bus.out_word  = word;
  assign bus.out_index = index;
  assign bus.out_last  = last;
  assign bus.busy      = (state != IDLE);
  assign bus.done      = (state == DONE);
  assign bus.err       = err_q;

endmodule

// File: tb/tb_ones_word_enum.sv
// Directed bench for ones_word_enum; expected words come from a brute-force popcount search.
module tb_ones_word_enum;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;

  ones_word_enum_if #(.WIDTH(12), .CW(4), .IW(10)) bus ();

  ones_word_enum #(.WIDTH(12), .CW(4), .IW(10)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [11:0] nxt(input logic [11:0] w, input int kk);
    for (int v = int'(w) + 1; v < 4096; v++) begin
      logic [11:0] vv;
      vv = v[11:0];
      if ($countones(vv) == kk) return vv;
    end
    return 12'h000;
  endfunction

  task automatic pulse_start(input logic [3:0] c);
    bus.start = 1'b1;
    bus.count = c;
    step();
    bus.start = 1'b0;
    bus.count = 4'd0;
  endtask

  task automatic check_done();
    check("done_valid", 32'(bus.out_valid), 32'd0);
    check("done_pulse", 32'(bus.done), 32'd1);
    check("done_busy",  32'(bus.busy), 32'd1);
    step();
    check("idle_busy",  32'(bus.busy), 32'd0);
    check("idle_done",  32'(bus.done), 32'd0);
  endtask

  initial begin
    logic [11:0] exp_w;
    int got;
    int cyc;

    bus.start = 1'b0;
    bus.count = 4'd0;
    bus.out_ready = 1'b1;
    step();
    step();
    check("rst_valid", 32'(bus.out_valid), 32'd0);
    check("rst_word",  32'(bus.out_word),  32'd0);
    check("rst_index", 32'(bus.out_index), 32'd0);
    check("rst_last",  32'(bus.out_last),  32'd0);
    check("rst_busy",  32'(bus.busy),      32'd0);
    check("rst_done",  32'(bus.done),      32'd0);
    check("rst_err",   32'(bus.err),       32'd0);
    rst = 1'b0;
    step();

    // k = 12: single all-ones word
    pulse_start(4'd12);
    check("k12_valid", 32'(bus.out_valid), 32'd1);
    check("k12_word",  32'(bus.out_word),  32'hFFF);
    check("k12_index", 32'(bus.out_index), 32'd0);
    check("k12_last",  32'(bus.out_last),  32'd1);
    step();
    check_done();

    // k = 0: single zero word
    pulse_start(4'd0);
    check("k0_valid", 32'(bus.out_valid), 32'd1);
    check("k0_word",  32'(bus.out_word),  32'h000);
    check("k0_last",  32'(bus.out_last),  32'd1);
    step();
    check_done();

    // k = 1: walking one
    pulse_start(4'd1);
    for (int i = 0; i < 12; i++) begin
      check("k1_valid", 32'(bus.out_valid), 32'd1);
      check("k1_word",  32'(bus.out_word),  32'(1) << i);
      check("k1_index", 32'(bus.out_index), 32'(i));
      check("k1_last",  32'(bus.out_last),  32'(i == 11));
      step();
    end
    check_done();

    // k = 2 with random back-pressure
    pulse_start(4'd2);
    exp_w = 12'h003;
    got = 0;
    cyc = 0;
    while (got < 66 && cyc < 2000) begin
      check("k2_valid", 32'(bus.out_valid), 32'd1);
      check("k2_word",  32'(bus.out_word),  32'(exp_w));
      check("k2_index", 32'(bus.out_index), 32'(got));
      check("k2_last",  32'(bus.out_last),  32'(got == 65));
      bus.out_ready = 1'($urandom_range(0, 1));
      if (bus.out_ready) begin
        got++;
        exp_w = nxt(exp_w, 2);
      end
      step();
      cyc++;
    end
    check("k2_count", 32'(got), 32'd66);
    bus.out_ready = 1'b1;
    check_done();

    // k = 6 full stream; starts issued mid-stream must be ignored
    pulse_start(4'd6);
    exp_w = 12'h03F;
    for (int i = 0; i < 924; i++) begin
      check("k6_word",  32'(bus.out_word),  32'(exp_w));
      check("k6_index", 32'(bus.out_index), 32'(i));
      check("k6_last",  32'(bus.out_last),  32'(i == 923));
      if (i == 923) check("k6_final", 32'(bus.out_word), 32'hFC0);
      bus.start = (i == 100) || (i == 500);
      bus.count = 4'd3;
      exp_w = nxt(exp_w, 6);
      step();
      bus.start = 1'b0;
    end
    check_done();

    // count = 13 rejected
    pulse_start(4'd13);
    check("err_pulse", 32'(bus.err),       32'd1);
    check("err_valid", 32'(bus.out_valid), 32'd0);
    check("err_busy",  32'(bus.busy),      32'd0);
    step();
    check("err_clear", 32'(bus.err),       32'd0);
    check("err_valid2", 32'(bus.out_valid), 32'd0);

    // k = 6 interrupted by reset after 100 words
    pulse_start(4'd6);
    for (int i = 0; i < 100; i++) step();
    check("mid_index", 32'(bus.out_index), 32'd100);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mr_valid", 32'(bus.out_valid), 32'd0);
    check("mr_word",  32'(bus.out_word),  32'd0);
    check("mr_index", 32'(bus.out_index), 32'd0);
    check("mr_last",  32'(bus.out_last),  32'd0);
    check("mr_busy",  32'(bus.busy),      32'd0);
    check("mr_done",  32'(bus.done),      32'd0);
    step();
    check("mr_done2", 32'(bus.done),      32'd0);

    // restart with k = 3
    pulse_start(4'd3);
    check("k3_first", 32'(bus.out_word),  32'h007);
    check("k3_index", 32'(bus.out_index), 32'd0);
    step();
    check("k3_second", 32'(bus.out_word), 32'h00B);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
